// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window.
// Emits only interior windows, one registered window per accepted pixel.
module window_gen_3x3 #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [7:0]  i_pixel,
   input  logic        i_pixel_valid,
   output logic [71:0] o_pixel_data,
   output logic        o_pixel_data_valid,
   output logic        o_frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   logic [7:0] lb1_q [IMG_WIDTH];
   logic [7:0] lb2_q [IMG_WIDTH];

   // Only the two previous columns are stored; the third comes from a/b/p.
   logic [7:0] top_q [2];
   logic [7:0] mid_q [2];
   logic [7:0] bot_q [2];

   logic [7:0]  rd_a, rd_b;
   logic        last_col, last_row;
   logic        emit, frame_end;
   logic [71:0] win_d;

   assign rd_a = lb2_q[col_q];
   assign rd_b = lb1_q[col_q];

   assign last_col  = (col_q == COL_LAST);
   assign last_row  = (row_q == ROW_LAST);
   assign emit      = i_pixel_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));
   assign frame_end = i_pixel_valid && last_col && last_row;

   assign win_d = {i_pixel, bot_q[1], bot_q[0],
                   rd_b,    mid_q[1], mid_q[0],
                   rd_a,    top_q[1], top_q[0]};

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (i_pixel_valid) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         col_q              <= '0;
         row_q              <= '0;
         o_pixel_data       <= '0;
         o_pixel_data_valid <= 1'b0;
         o_frame_done       <= 1'b0;
      end else begin
         col_q              <= col_d;
         row_q              <= row_d;
         o_pixel_data_valid <= emit;
         o_frame_done       <= frame_end;
         if (emit) begin
            o_pixel_data <= win_d;
         end
      end
   end

   // Storage is never cleared: row < 2 keeps stale contents off the output.
   always_ff @(posedge i_clk) begin
      if (i_pixel_valid) begin
         lb2_q[col_q] <= rd_b;
         lb1_q[col_q] <= i_pixel;
         top_q[0]     <= top_q[1];
         top_q[1]     <= rd_a;
         mid_q[0]     <= mid_q[1];
         mid_q[1]     <= rd_b;
         bot_q[0]     <= bot_q[1];
         bot_q[1]     <= i_pixel;
      end
   end

endmodule
